// File: rtl/sonic_echo_if.sv
// Ranging bus between a trigger initiator and an echo responder.
// The master drives trig and the requested distance; the slave answers.
interface sonic_echo_if;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo;
    logic       busy;
    logic [7:0] req_count;

    modport master (
        output trig,
        output distance_cm,
        input  echo,
        input  busy,
        input  req_count
    );

    modport slave (
        input  trig,
        input  distance_cm,
        output echo,
        output busy,
        output req_count
    );
endinterface

// File: rtl/sonic_echo_model.sv
// HC-SR04 style responder: accepts a qualified trig pulse and returns
// an echo pulse whose width encodes the programmed distance.
module sonic_echo_model #(
    parameter int unsigned TRIG_MIN_CYC = 1000,
    parameter int unsigned BURST_CYC    = 20000,
    parameter int unsigned CYC_PER_CM   = 5800,
    parameter int unsigned MAX_CM       = 400,
    parameter int unsigned TIMEOUT_CYC  = 3800000,
    parameter int unsigned HOLDOFF_CYC  = 1000000
) (
    input logic         clk,
    input logic         rst,
    sonic_echo_if.slave bus
);
    localparam logic [21:0] TRIG_MIN = 22'(TRIG_MIN_CYC);
    localparam logic [21:0] BURST    = 22'(BURST_CYC);
    localparam logic [21:0] CPC      = 22'(CYC_PER_CM);
    localparam logic [21:0] TIMEOUT  = 22'(TIMEOUT_CYC);
    localparam logic [21:0] HOLDOFF  = 22'(HOLDOFF_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t      state_q, state_d;
    logic        trig_m_q, trig_s_q, trig_p_q;
    logic [21:0] cnt_q, cnt_d;
    logic [21:0] width_q, width_d;
    logic        echo_q, echo_d;
    logic        busy_q, busy_d;
    logic [7:0]  req_q, req_d;
    logic        trig_rise;
    logic        in_range;
    logic [21:0] req_width;

    assign trig_rise = trig_s_q & ~trig_p_q;

    // Echo width for the distance currently on the bus
    always_comb begin
        in_range  = (bus.distance_cm != 9'd0) &&
                    (32'(bus.distance_cm) <= MAX_CM);
        req_width = TIMEOUT;
        if (in_range) begin
            req_width = 22'(bus.distance_cm) * CPC;
        end
    end

    // Next-state logic; one shared down/up counter serves every phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        echo_d  = echo_q;
        busy_d  = busy_q;
        req_d   = req_q;
        unique case (state_q)
            S_IDLE: begin
                // The rising-edge cycle is itself the first high sample
                if (trig_rise) begin
                    cnt_d   = 22'd1;
                    state_d = S_TRIG_HI;
                end
            end
            S_TRIG_HI: begin
                if (trig_s_q) begin
                    if (cnt_q < TRIG_MIN) begin
                        cnt_d = cnt_q + 22'd1;
                    end
                end else if (cnt_q >= TRIG_MIN) begin
                    state_d = S_BURST;
                    cnt_d   = BURST;
                    width_d = req_width;
                    req_d   = req_q + 8'd1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (cnt_q <= 22'd1) begin
                    state_d = S_ECHO;
                    cnt_d   = width_q;
                    echo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 22'd1;
                end
            end
            S_ECHO: begin
                if (cnt_q <= 22'd1) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = HOLDOFF;
                    echo_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 22'd1;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q <= 22'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 22'd0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 22'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Trigger synchronizer plus previous-value flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_m_q <= 1'b0;
            trig_s_q <= 1'b0;
            trig_p_q <= 1'b0;
        end else begin
            trig_m_q <= bus.trig;
            trig_s_q <= trig_m_q;
            trig_p_q <= trig_s_q;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 22'd0;
            width_q <= 22'd0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            echo_q  <= echo_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
        end
    end

    assign bus.echo      = echo_q;
    assign bus.busy      = busy_q;
    assign bus.req_count = req_q;
endmodule
